uart_frame_assembler: RTL and testbench
=======================================

# uart_frame_assembler

- Sits between `uart_rx` and `pwm_9ch` inside the UART-PWM top.
- Collects byte strobes from the receiver and assembles them MSB-first into 16-bit duty words.
- Fills a 9-channel shadow bank and commits all channels to the PWM duty bus atomically when a full 18-byte frame completes.
- Discards partial frames on an inter-byte timeout, flags the error, and keeps a packet counter for the seven-segment display.

## Interface
Parameters:
- `NUM_CH`, 9: duty channels per frame.
- `WORD_W`, 16: bits per duty word (two bytes).
- `TIMEOUT_CLKS`, 50000: idle cycles mid-frame before abort (1 ms at 50 MHz).

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx_data` input 8: received byte, valid only when `rx_valid`=1.
- `rx_valid` input 1: one-cycle strobe per received byte.
- `duty_flat` output NUM_CH*WORD_W: committed duties; channel k at `[k*WORD_W +: WORD_W]`.
- `duty_update` output 1: one-cycle pulse when `duty_flat` changes.
- `pkt_count` output 4: completed frames, modulo 16.
- `frame_err` output 1: one-cycle pulse on timeout abort.
- `busy` output 1: high while a frame is partially received.

## Operation
- Frame length is 2*NUM_CH = 18 bytes: ch0 hi, ch0 lo, ch1 hi, …, ch8 lo.
- Byte index `byte_cnt` runs 0..17. Even index writes `shadow[byte_cnt>>1][15:8]`; odd index writes `[7:0]`.
- State machine, two states:
  - IDLE (`busy`=0): on `rx_valid`, store the byte as ch0 hi, set `byte_cnt`=1, clear the timeout counter, go to RECV.
  - RECV (`busy`=1): on `rx_valid`, store at `byte_cnt`, clear the timeout counter.
    - If `byte_cnt`=17: commit and go to IDLE.
    - Otherwise: increment `byte_cnt`.
  - RECV without `rx_valid`: increment the timeout counter. When it reaches TIMEOUT_CLKS-1 and no byte arrives that cycle, abort.
- Commit, all on one edge:
  - `duty_flat` ← shadow bank, with the 18th byte included.
  - `duty_update`=1 for one cycle.
  - `pkt_count` increments, wrapping 15→0.
- Abort:
  - Go to IDLE, `byte_cnt`=0, `frame_err`=1 for one cycle.
  - `duty_flat` and `pkt_count` are unchanged.
  - Shadow contents are don't-care; they are overwritten by the next frame.
- Priority:
  - `rx_valid` beats timeout expiry on the same cycle: the byte is accepted and the counter restarts.
  - `rst` beats everything.
- No timeout runs in IDLE; arbitrary idle gaps are legal.
- Timeout counter width is $clog2(TIMEOUT_CLKS).

## Timing
- Reset values: `duty_flat`=0, `duty_update`=0, `pkt_count`=0, `frame_err`=0, `busy`=0. State=IDLE, `byte_cnt`=0, timeout counter=0, shadow=0.
- `rst` asserted mid-frame discards the frame immediately (asynchronously), with no `frame_err` and no `duty_update`.
- Commit latency: `duty_flat`, `duty_update` and `pkt_count` update at the first rising edge that samples the 18th `rx_valid`.
- Pulse and status timing:
  - `busy` rises at the edge sampling the 1st byte and falls at the commit or abort edge.
  - `duty_update` and `frame_err` are registered, exactly one cycle wide, and never asserted together.
- Back-to-back frames: a byte strobe on the cycle after a commit starts the next frame normally.
- Abort timing: with the last byte at edge T, abort occurs at edge T+TIMEOUT_CLKS.

## Test plan
- Reset, then send words 0001,0002,0003,6666,8888,AAAA,CCCC,EEEE,FFFF at 115200 baud. Required: one `duty_update` pulse, `duty_flat[15:0]`=0001 … `[143:128]`=FFFF, `pkt_count`=1.
- Send 7 bytes, then idle for TIMEOUT_CLKS cycles. Required: `frame_err` pulse at edge T+TIMEOUT_CLKS, `busy`=0, `duty_flat` and `pkt_count` unchanged.
- After the abort, send a full frame of 1234 ×9. Required: all channels =1234, `pkt_count` incremented by 1 (the aborted bytes are not merged).
- Send 17 consecutive valid frames. Required: `pkt_count` wraps 15→0→1, with one `duty_update` per frame.
- Assert `rst` after byte 10 of a frame. Required: all outputs at reset values immediately, no `duty_update`, and the next full frame is assembled correctly.
- Use reduced TIMEOUT_CLKS=8 and drive `rx_valid` exactly on the expiry cycle. Required: byte accepted, no `frame_err`; the frame then completes with the correct words.

Source files
------------

// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler: packs 18 MSB-first bytes into nine 16-bit duties, commits atomically, aborts partial frames on idle timeout
module uart_frame_assembler #(
  parameter int NUM_CH       = 9,
  parameter int WORD_W       = 16,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [NUM_CH*WORD_W-1:0]   duty_flat,
  output logic                       duty_update,
  output logic [3:0]                 pkt_count,
  output logic                       frame_err,
  output logic                       busy
);
  localparam int BW = $clog2(2*NUM_CH);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state;
  logic [BW-1:0] byte_cnt, idx;
  logic [TW-1:0] to_cnt;
  logic [NUM_CH-1:0][WORD_W-1:0] shadow, shadow_nx;
  logic last;
  // An idle frame always starts at byte 0 regardless of leftover count
  assign idx  = state == RECV ? byte_cnt : '0;
  assign last = idx == BW'(2*NUM_CH-1);
  assign busy = state == RECV;
  // Shadow bank with the incoming byte merged, so a commit can include the final byte
  always_comb begin
    shadow_nx = shadow;
    if (rx_valid) shadow_nx[idx[BW-1:1]][(idx[0] ? 0 : 8) +: 8] = rx_data;
  end
  // Frame FSM: byte accept beats timeout, commit/abort pulses are one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      shadow      <= '0;
      duty_flat   <= '0;
      duty_update <= 1'b0;
      pkt_count   <= '0;
      frame_err   <= 1'b0;
    end else begin
      duty_update <= 1'b0;
      frame_err   <= 1'b0;
      if (rx_valid) begin
        shadow <= shadow_nx;
        to_cnt <= '0;
        if (last) begin
          state       <= IDLE;
          byte_cnt    <= '0;
          duty_flat   <= shadow_nx;
          duty_update <= 1'b1;
          pkt_count   <= pkt_count + 4'd1;
        end else begin
          state    <= RECV;
          byte_cnt <= idx + 1'b1;
        end
      end else if (state == RECV) begin
        if (to_cnt == TW'(TIMEOUT_CLKS-1)) begin
          state     <= IDLE;
          byte_cnt  <= '0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_assembler.sv
// tb_uart_frame_assembler: table vectors, corner sequences and a queue-based frame model
module tb_uart_frame_assembler;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic [143:0] duty_flat;
  logic duty_update, frame_err, busy;
  logic [3:0] pkt_count;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];
  int idle = 0;
  logic [143:0] m_duty = '0;
  logic [3:0] m_pkt = '0;
  logic m_upd = 1'b0, m_err = 1'b0;
  typedef struct {
    logic v;
    logic [7:0] d;
    logic upd;
    logic bsy;
    logic [3:0] pkt;
  } vec_t;
  vec_t tbl[18];
  logic [15:0] words[9] = '{16'h0001, 16'h0002, 16'h0003, 16'h6666, 16'h8888,
                            16'hAAAA, 16'hCCCC, 16'hEEEE, 16'hFFFF};

  uart_frame_assembler #(.NUM_CH(9), .WORD_W(16), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .duty_flat(duty_flat), .duty_update(duty_update), .pkt_count(pkt_count),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    idle = 0;
    m_duty = '0;
    m_pkt = '0;
    m_upd = 1'b0;
    m_err = 1'b0;
  endtask

  // Frame-level reference: a byte queue that commits at 18 entries or is dropped after TO idle cycles
  task automatic model_edge(input logic v, input logic [7:0] d);
    m_upd = 1'b0;
    m_err = 1'b0;
    if (v) begin
      q.push_back(d);
      idle = 0;
      if (q.size() == 18) begin
        for (int k = 0; k < 9; k++) m_duty[k*16 +: 16] = {q[2*k], q[2*k+1]};
        m_upd = 1'b1;
        m_pkt = m_pkt + 4'd1;
        q.delete();
      end
    end else if (q.size() != 0) begin
      idle++;
      if (idle == TO) begin
        q.delete();
        idle = 0;
        m_err = 1'b1;
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    check("duty_flat", duty_flat, m_duty);
    check("duty_update", duty_update, m_upd);
    check("frame_err", frame_err, m_err);
    check("busy", busy, q.size() != 0);
    check("pkt_count", pkt_count, m_pkt);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) step(1'b0, 8'h00);
    step(1'b1, b);
  endtask

  task automatic send_random_frame(input int maxgap);
    for (int i = 0; i < 18; i++) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, maxgap));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_duty"}, duty_flat, '0);
    check({tag, "_upd"}, duty_update, 1'b0);
    check({tag, "_err"}, frame_err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_pkt"}, pkt_count, 4'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 18; i++)
      tbl[i] = '{1'b1, i[0] ? words[i/2][7:0] : words[i/2][15:8], i == 17, i != 17, (i == 17) ? 4'd1 : 4'd0};
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].v, tbl[i].d);
      check("tbl_upd", duty_update, tbl[i].upd);
      check("tbl_busy", busy, tbl[i].bsy);
      check("tbl_pkt", pkt_count, tbl[i].pkt);
    end
    check("frame1_words", duty_flat,
          144'hFFFF_EEEE_CCCC_AAAA_8888_6666_0003_0002_0001);
    step(1'b0, 8'h00);
    check("frame1_single_pulse", duty_update, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'hA5);
    for (int i = 1; i <= TO; i++) begin
      step(1'b0, 8'h00);
      check("abort_err_timing", frame_err, i == TO);
      check("abort_busy", busy, i != TO);
    end
    check("abort_duty_kept", duty_flat, 144'hFFFF_EEEE_CCCC_AAAA_8888_6666_0003_0002_0001);
    check("abort_pkt_kept", pkt_count, 4'd1);
    step(1'b0, 8'h00);
    for (int i = 0; i < 18; i++) send_byte(i[0] ? 8'h34 : 8'h12, i % 3);
    check("frame1234", duty_flat, {9{16'h1234}});
    check("frame1234_pkt", pkt_count, 4'd2);
    for (int f = 0; f < 17; f++) send_random_frame(TO - 1);
    check("wrap_pkt", pkt_count, 4'd3);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), 0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1 check("rst_no_update", duty_update, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) send_byte(8'(8'h40 + i), 0);
    check("post_rst_frame", duty_flat,
          144'h5051_4E4F_4C4D_4A4B_4849_4647_4445_4243_4041);
    check("post_rst_pkt", pkt_count, 4'd1);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 0);
    for (int i = 0; i < TO - 1; i++) begin
      step(1'b0, 8'h00);
      check("expiry_no_err", frame_err, 1'b0);
    end
    step(1'b1, 8'hC5);
    check("expiry_accept_busy", busy, 1'b1);
    check("expiry_accept_err", frame_err, 1'b0);
    for (int i = 6; i < 18; i++) send_byte(8'(8'hC0 + i), TO - 1);
    check("expiry_frame", duty_flat,
          144'hD0D1_CECF_CCCD_CACB_C8C9_C6C7_C4C5_C2C3_C0C1);
    check("expiry_pkt", pkt_count, 4'd2);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 6) step(1'b1, 8'($urandom_range(0, 255)));
      else repeat ($urandom_range(1, TO + 2)) step(1'b0, 8'h00);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
